// File: rtl/a_row_loader.sv
// a_row_loader: gathers a DIM x DIM signed matrix streamed row-major, writes
// each completed row to the downstream A memory with a one-cycle WrEn strobe,
// then drives the memory shift enable for 3*DIM-2 cycles and pulses done.
module a_row_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic signed [BITS_AB-1:0] in_data,
  output logic                      in_ready,
  output logic signed [BITS_AB-1:0] Ain [0:DIM-1],
  output logic [$clog2(DIM)-1:0]    Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  localparam int IW        = $clog2(DIM);
  localparam int DRAIN_LEN = 3 * DIM - 2;
  localparam int DW        = $clog2(DRAIN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IW-1:0]             col;
  logic [IW-1:0]             row;
  logic [DW-1:0]             dcnt;
  // Set by the last element of the last row: holds off further input during
  // the final row-write cycle before the drain starts.
  logic                      full;
  logic signed [BITS_AB-1:0] row_buf [0:DIM-1];

  logic accept;
  logic row_end;
  logic last_row;
  logic drain_end;

  assign accept    = in_valid && in_ready;
  assign row_end   = accept && (col == IW'(DIM - 1));
  assign last_row  = (row == IW'(DIM - 1));
  assign drain_end = (state == DRAIN) && (dcnt == DW'(DRAIN_LEN - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; clr overrides everything, start is
  // only looked at in IDLE
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    en        = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = !full;
        if (full) state_nxt = DRAIN;
      end
      DRAIN: begin
        en = 1'b1;
        if (drain_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Column/row/drain counters plus the row-write and done strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      dcnt <= '0;
      full <= 1'b0;
      WrEn <= 1'b0;
      done <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      done <= 1'b0;
      if (clr) begin
        col  <= '0;
        row  <= '0;
        dcnt <= '0;
        full <= 1'b0;
      end else begin
        if (accept) begin
          // DIM is a power of two, so both counters wrap naturally
          col <= col + 1'b1;
          if (row_end) begin
            WrEn <= 1'b1;
            row  <= row + 1'b1;
            if (last_row) full <= 1'b1;
          end
        end
        if (state == DRAIN) begin
          full <= 1'b0;
          dcnt <= drain_end ? '0 : dcnt + 1'b1;
        end
        done <= drain_end;
      end
    end
  end

  // Row assembly buffer; every column is rewritten before a row is emitted
  always_ff @(posedge clk) begin
    if (accept) row_buf[col] <= in_data;
  end

  // Published row and its index, held until the next row write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Arow <= '0;
      for (int c = 0; c < DIM; c++) Ain[c] <= '0;
    end else if (row_end && !clr) begin
      Arow <= row;
      for (int c = 0; c < DIM; c++) begin
        Ain[c] <= (c == DIM - 1) ? in_data : row_buf[c];
      end
    end
  end

endmodule

// File: tb/tb_a_row_loader.sv
// tb_a_row_loader: scoreboard bench for a_row_loader. The driver pushes the
// expected row writes and done pulses as it streams elements; a negedge
// monitor pops and compares them when the DUT produces them.
module tb_a_row_loader;

  localparam int DIM = 8;
  localparam int BW  = 8;
  localparam int DRAIN_LEN = 3 * DIM - 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 clr;
  logic                 in_valid;
  logic signed [BW-1:0] in_data;
  logic                 in_ready;
  logic signed [BW-1:0] Ain [0:DIM-1];
  logic [$clog2(DIM)-1:0] Arow;
  logic                 WrEn;
  logic                 en;
  logic                 busy;
  logic                 done;

  a_row_loader #(.BITS_AB(BW), .DIM(DIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .Ain      (Ain),
    .Arow     (Arow),
    .WrEn     (WrEn),
    .en       (en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              row;
    int              cyc;
    logic [DIM*BW-1:0] data;
  } row_exp_t;

  row_exp_t             exp_q [$];
  int                   done_q [$];
  logic signed [BW-1:0] mat [0:DIM*DIM-1];
  int                   cyc = 0;
  int                   en_run = 0;
  int                   total = 0;
  int                   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: row writes, drain length, done pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      en_run = 0;
    end else begin
      if (WrEn) begin
        chk("wr_en_excl", en, 0);
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", WrEn, 0);
        end else begin
          row_exp_t e;
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("arow", Arow, e.row);
          for (int c = 0; c < DIM; c++) chk("ain", Ain[c], $signed(e.data[c*BW +: BW]));
        end
      end
      if (en) en_run++;
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("en_run", en_run, DRAIN_LEN);
          chk("busy_at_done", busy, 0);
        end
      end
      if (!en) en_run = 0;
    end
  end

  // Stream n elements of mat; throttle inserts an idle cycle after each one
  task automatic send_elems(input int n, input bit throttle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = mat[i];
      if (i % DIM == DIM - 1) begin
        row_exp_t e;
        e.row = i / DIM;
        e.cyc = cyc + 1;
        for (int c = 0; c < DIM; c++) e.data[c*BW +: BW] = mat[i - DIM + 1 + c];
        exp_q.push_back(e);
        if (i == DIM * DIM - 1) done_q.push_back(cyc + 1 + DRAIN_LEN + 1);
      end
      if (throttle) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy || done_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("idle_timeout", busy, 0);
    chk("done_missing", done_q.size(), 0);
    chk("rows_missing", exp_q.size(), 0);
  endtask

  task automatic wait_en(input int limit);
    int n;
    n = 0;
    while (!en && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_reached", en, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    start = 0; clr = 0; in_valid = 0; in_data = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wren", WrEn, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arow", Arow, 0);
    for (int c = 0; c < DIM; c++) chk("rst_ain", Ain[c], 0);
    rst_n = 1'b1;

    // in_valid while idle is ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'sd55;
      chk("idle_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_ain0", Ain[DIM-1], 0);

    // clr together with start stays idle
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", busy, 0);
    @(negedge clk);
    chk("clr_start_busy2", busy, 0);

    // back-to-back load 0..63
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(i);
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    chk("b2b_last_ready", in_ready, 0);
    wait_idle(200);

    // throttled negative data
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(-1 - i);
    pulse_start();
    send_elems(DIM*DIM, 1'b1);
    wait_idle(200);

    // random data with signed extremes
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'($urandom_range(0, 255));
    mat[0] = -8'sd128; mat[9] = 8'sd127; mat[DIM*DIM-1] = -8'sd128;
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    wait_idle(200);

    // clr after 20 elements
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(i + 100);
    pulse_start();
    send_elems(20, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_arow_held", Arow, 1);
    chk("clr_ain_held", Ain[0], 8 + 100);
    repeat (12) @(negedge clk);
    chk("clr_rows_left", exp_q.size(), 0);
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(3 * i - 90);
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    wait_idle(200);

    // start during drain is ignored
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(i ^ 8'h5a);
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    wait_en(10);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("post_drain_busy", busy, 0);
    chk("post_drain_ready", in_ready, 0);

    // reset during drain cycle 5
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(2 * i + 1);
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    wait_en(10);
    repeat (4) @(negedge clk);
    exp_q.delete();
    done_q.delete();
    rst_n = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wren", WrEn, 0);
    chk("arst_done", done, 0);
    chk("arst_arow", Arow, 0);
    chk("arst_ain", Ain[3], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("arst_en_after", en, 0);
    end
    chk("arst_busy_after", busy, 0);

    // fresh load after reset begins at row 0, col 0
    for (int i = 0; i < DIM*DIM; i++) mat[i] = BW'(63 - i);
    pulse_start();
    send_elems(DIM*DIM, 1'b0);
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
